// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
// Optional build macro: STALL_STATS_EN (adds 32-bit stall/flush statistics counters).
package pipeline_pkg;

  // FSM encoding of the stall controller
  typedef enum logic [1:0] {
    RUN = 2'd0,
    HAZ = 2'd1,
    MEM = 2'd2,
    REL = 2'd3
  } stall_state_t;

  // Default number of consecutive hazard-stall cycles before forced release
  localparam int DEF_MAX_HAZ_STALL = 3;

  // Width of the optional statistics counters
  localparam int STATS_W = 32;

endpackage : pipeline_pkg

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Up-counter with synchronous clear and optional saturation at all-ones.
// With SATURATE=0 the counter wraps modulo 2^WIDTH.
module sat_counter #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear has priority over increment; hold at all-ones when saturating
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      if (SATURATE && (&count_q)) begin
        count_d = count_q;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  // Count register, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline.
// Mealy control outputs (same-cycle response to hazards), registered FSM,
// consecutive-stall counter and a sticky watchdog that force-releases a
// hazard stall that lasts MAX_HAZ_STALL cycles.
// Optional build macro: STALL_STATS_EN adds hazStallTotal, memStallTotal
// and flushTotal (32-bit, wrapping) event counters.
module pipeline_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int MAX_HAZ_STALL = DEF_MAX_HAZ_STALL,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hazardDetected,
  input  logic             branchTakenD,
  input  logic             memBusyM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic [CNT_W-1:0] stallCycles,
`ifdef STALL_STATS_EN
  output logic [STATS_W-1:0] hazStallTotal,
  output logic [STATS_W-1:0] memStallTotal,
  output logic [STATS_W-1:0] flushTotal,
`endif
  output logic             timeoutErr
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HAZ_STALL);

  stall_state_t     state_q;
  stall_state_t     state_d;
  logic             timeout_q;
  logic             timeout_d;

  logic             cnt_inc;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_plus1;

  logic             stall_f_w;
  logic             stall_d_w;
  logic             stall_e_w;
  logic             stall_m_w;
  logic             flush_d_w;
  logic             flush_e_w;

  // Value the counter will hold after an increment this cycle (saturating)
  assign cnt_plus1 = (&stallCycles) ? stallCycles : (stallCycles + CNT_W'(1));

  // Next-state, counter control and Mealy outputs; memory busy beats hazard beats branch
  always_comb begin
    state_d   = RUN;
    timeout_d = timeout_q;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    stall_f_w = 1'b0;
    stall_d_w = 1'b0;
    stall_e_w = 1'b0;
    stall_m_w = 1'b0;
    flush_d_w = 1'b0;
    flush_e_w = 1'b0;

    if (memBusyM) begin
      // Whole front of the pipe waits on memory; the watchdog never applies here
      stall_f_w = 1'b1;
      stall_d_w = 1'b1;
      stall_e_w = 1'b1;
      stall_m_w = 1'b1;
      cnt_inc   = 1'b1;
      state_d   = MEM;
    end else if (state_q == REL) begin
      // One free cycle to let the stuck instruction move on
      cnt_clr = 1'b1;
      state_d = RUN;
    end else if (hazardDetected) begin
      // Hold PC and IF/ID, bubble into ID/EX; a coincident branch waits for re-decode
      stall_f_w = 1'b1;
      stall_d_w = 1'b1;
      flush_e_w = 1'b1;
      cnt_inc   = 1'b1;
      if (cnt_plus1 >= MAX_CNT) begin
        state_d   = REL;
        timeout_d = 1'b1;
      end else begin
        state_d = HAZ;
      end
    end else begin
      flush_d_w = branchTakenD;
      cnt_clr   = 1'b1;
      state_d   = RUN;
    end

    // Controls are forced inactive while reset is asserted
    if (reset) begin
      stall_f_w = 1'b0;
      stall_d_w = 1'b0;
      stall_e_w = 1'b0;
      stall_m_w = 1'b0;
      flush_d_w = 1'b0;
      flush_e_w = 1'b0;
    end
  end

  // FSM state and sticky watchdog flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(
    .WIDTH    (CNT_W),
    .SATURATE (1'b1)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (stallCycles)
  );

`ifdef STALL_STATS_EN
  // Hazard stall is the only case that holds decode without holding EX/MEM
  sat_counter #(
    .WIDTH    (STATS_W),
    .SATURATE (1'b0)
  ) u_haz_total (
    .clk   (clk),
    .rst   (reset),
    .clr   (1'b0),
    .inc   (stall_d_w & ~stall_m_w),
    .count (hazStallTotal)
  );

  sat_counter #(
    .WIDTH    (STATS_W),
    .SATURATE (1'b0)
  ) u_mem_total (
    .clk   (clk),
    .rst   (reset),
    .clr   (1'b0),
    .inc   (stall_m_w),
    .count (memStallTotal)
  );

  sat_counter #(
    .WIDTH    (STATS_W),
    .SATURATE (1'b0)
  ) u_flush_total (
    .clk   (clk),
    .rst   (reset),
    .clr   (1'b0),
    .inc   (flush_d_w),
    .count (flushTotal)
  );
`endif

  assign stallF     = stall_f_w;
  assign stallD     = stall_d_w;
  assign stallE     = stall_e_w;
  assign stallM     = stall_m_w;
  assign flushD     = flush_d_w;
  assign flushE     = flush_e_w;
  assign timeoutErr = timeout_q;

endmodule : pipeline_stall_ctrl

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl (default MAX_HAZ_STALL=3, CNT_W=4).
// Build with +define+STALL_STATS_EN to also exercise the statistics counters.
module tb_pipeline_stall_ctrl;

  logic       clk;
  logic       reset;
  logic       hazardDetected;
  logic       branchTakenD;
  logic       memBusyM;
  logic       stallF, stallD, stallE, stallM, flushD, flushE;
  logic [3:0] stallCycles;
  logic       timeoutErr;
`ifdef STALL_STATS_EN
  logic [31:0] hazStallTotal, memStallTotal, flushTotal;
`endif

  // Control vector order: {stallF, stallD, stallE, stallM, flushD, flushE}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_HAZ  = 6'b110001;
  localparam logic [5:0] C_MEM  = 6'b111100;
  localparam logic [5:0] C_BR   = 6'b000010;

  typedef struct {
    logic [5:0] ctl;
    logic [3:0] cnt;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic [5:0] ctl_w;

  assign ctl_w = {stallF, stallD, stallE, stallM, flushD, flushE};

  pipeline_stall_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .hazardDetected (hazardDetected),
    .branchTakenD   (branchTakenD),
    .memBusyM       (memBusyM),
    .stallF         (stallF),
    .stallD         (stallD),
    .stallE         (stallE),
    .stallM         (stallM),
    .flushD         (flushD),
    .flushE         (flushE),
    .stallCycles    (stallCycles),
`ifdef STALL_STATS_EN
    .hazStallTotal  (hazStallTotal),
    .memStallTotal  (memStallTotal),
    .flushTotal     (flushTotal),
`endif
    .timeoutErr     (timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One pipeline cycle: drive inputs, check Mealy outputs mid-cycle, registered state after the edge
  task automatic step(input string tag, input logic h, input logic b, input logic m,
                      input logic [5:0] ectl, input logic [3:0] ecnt, input logic eto);
    exp_t e;
    exp_t got;
    hazardDetected = h;
    branchTakenD   = b;
    memBusyM       = m;
    e.ctl = ectl;
    e.cnt = ecnt;
    e.to  = eto;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      $display("FAIL %s.sb: scoreboard empty", tag);
      n_errors++;
      n_checks++;
      return;
    end
    got = sb_q.pop_front();
    check({tag, ".ctl"}, 32'(ctl_w), 32'(got.ctl));
    @(posedge clk);
    #1;
    check({tag, ".cnt"}, 32'(stallCycles), 32'(got.cnt));
    check({tag, ".to"},  32'(timeoutErr),  32'(got.to));
    $display("txn %-10s h=%b b=%b m=%b ctl=%b cnt=%0d to=%b", tag, h, b, m, ctl_w, stallCycles, timeoutErr);
  endtask

  initial begin
    // Reset held with every input active: controls must still be 0
    reset = 1'b1;
    hazardDetected = 1'b1;
    branchTakenD   = 1'b1;
    memBusyM       = 1'b1;
    #3;
    check("por.ctl", 32'(ctl_w), 32'(C_NONE));
    check("por.cnt", 32'(stallCycles), 32'd0);
    check("por.to",  32'(timeoutErr), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("idle0", 0, 0, 0, C_NONE, 0, 0);

    // Reset arriving in the middle of a hazard stall
    step("rst_h1", 1, 0, 0, C_HAZ, 1, 0);
    step("rst_h2", 1, 0, 0, C_HAZ, 2, 0);
    reset = 1'b1;
    #1;
    check("rst_mid.ctl", 32'(ctl_w), 32'(C_NONE));
    check("rst_mid.cnt", 32'(stallCycles), 32'd0);
    check("rst_mid.to",  32'(timeoutErr), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    hazardDetected = 1'b0;
    // Statistics start from zero here

    // Single two-cycle hazard
    step("haz1", 1, 0, 0, C_HAZ, 1, 0);
    step("haz2", 1, 0, 0, C_HAZ, 2, 0);
    step("haz_end", 0, 0, 0, C_NONE, 0, 0);

    // Branch against hazard: hazard wins, then branch alone flushes decode
    step("brhaz", 1, 1, 0, C_HAZ, 1, 0);
    step("br", 0, 1, 0, C_BR, 0, 0);
    step("br_end", 0, 0, 0, C_NONE, 0, 0);

`ifdef STALL_STATS_EN
    check("stat.haz",   hazStallTotal, 32'd3);
    check("stat.flush", flushTotal,    32'd1);
    check("stat.mem",   memStallTotal, 32'd0);
`endif

    // Memory busy outranks hazard and is exempt from the watchdog
    for (int i = 1; i <= 5; i++) begin
      step($sformatf("mem%0d", i), 1, 0, 1, C_MEM, 4'(i), 0);
    end
    step("mem_end", 0, 0, 0, C_NONE, 0, 0);

`ifdef STALL_STATS_EN
    check("stat.mem5", memStallTotal, 32'd5);
`endif

    // Watchdog: stuck hazard released on the fourth cycle
    step("wd1", 1, 0, 0, C_HAZ, 1, 0);
    step("wd2", 1, 0, 0, C_HAZ, 2, 0);
    step("wd3", 1, 0, 0, C_HAZ, 3, 1);
    step("wd4_rel", 1, 0, 0, C_NONE, 0, 1);
    step("wd5", 1, 0, 0, C_HAZ, 1, 1);
    step("wd6", 1, 0, 0, C_HAZ, 2, 1);
    step("wd_end", 0, 0, 0, C_NONE, 0, 1);

    // HAZ -> MEM -> HAZ keeps counting, so the third stall trips the release
    step("chain_h", 1, 0, 0, C_HAZ, 1, 1);
    step("chain_m", 1, 0, 1, C_MEM, 2, 1);
    step("chain_h2", 1, 0, 0, C_HAZ, 3, 1);
    step("chain_rel", 1, 1, 0, C_NONE, 0, 1);
    step("chain_end", 0, 0, 0, C_NONE, 0, 1);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_pipeline_stall_ctrl

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumes the combinational hazard flag from the decode-stage hazard detector, plus branch and data-memory busy indications.
- Produces per-stage stall (enable-hold) and flush (bubble) controls for the 5-stage MIPS pipeline registers.
- Adds a registered FSM with a consecutive-stall counter and a watchdog that force-releases a stuck hazard stall and records the event.
- Sits between the hazard detector and the IF/ID, ID/EX and EX/MEM pipeline registers and the PC register.

Parameters:
- MAX_HAZ_STALL, 3: maximum consecutive hazard-stall cycles before forced release; must be 1..(2^CNT_W - 1).
- CNT_W, 4: width of the consecutive-stall counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- hazardDetected  input  1  RAW hazard flag from the decode-stage detector, combinational, same cycle.
- branchTakenD  input  1  branch or jump resolved taken in decode.
- memBusyM  input  1  data memory not ready this cycle.
- stallF  output  1  hold PC.
- stallD  output  1  hold IF/ID.
- stallE  output  1  hold ID/EX.
- stallM  output  1  hold EX/MEM.
- flushD  output  1  clear IF/ID (squash fetched instruction).
- flushE  output  1  clear ID/EX (insert bubble).
- stallCycles  output  CNT_W  current consecutive stall count, saturating at all-ones.
- timeoutErr  output  1  sticky watchdog flag.

Behaviour:
- States: RUN, HAZ, MEM, REL. State is registered on the clock. Control outputs are Mealy: combinational from state and inputs, so a stall takes effect in the same cycle the hazard is flagged.
- Priority within a cycle: memBusyM > hazardDetected > branchTakenD.
- memBusyM=1, any state:
  - Outputs: stallF=stallD=stallE=stallM=1; flushD=flushE=0.
  - Next state: MEM.
  - stallCycles increments, saturating.
  - No watchdog applies.
- hazardDetected=1, memBusyM=0, state≠REL:
  - Outputs: stallF=stallD=1; flushE=1; stallE=stallM=0; flushD=0.
  - Next state: HAZ. stallCycles increments.
  - If the incremented count reaches MAX_HAZ_STALL: next state REL, and timeoutErr is set.
- branchTakenD=1 with no stall condition: flushD=1 for that cycle only; all other outputs 0.
  - If a branch coincides with a hazard, the hazard wins and flushD=0. The branch is re-evaluated when decode is re-presented.
- REL:
  - Lasts exactly one cycle. All stall and flush outputs are 0, even if hazardDetected=1; the only exception is that memBusyM still wins.
  - stallCycles clears. Next state follows the normal rules on the following cycle.
- No stall condition and state≠REL: all outputs 0, stallCycles clears to 0, next state RUN.
- Transitions HAZ→MEM or MEM→HAZ do not clear the counter. It clears only in a cycle with no stall condition, or in REL.
- timeoutErr stays at 1 until reset.
- Reset (asynchronous, takes effect mid-stall): state=RUN, stallCycles=0, timeoutErr=0.
  - All control outputs evaluate to 0 during reset, regardless of inputs.
  - On deassertion, behaviour resumes from RUN on the next edge.

Optional Feature:
- Macro STALL_STATS_EN.
- When defined, three extra outputs are added, each 32 bits: hazStallTotal, memStallTotal, flushTotal.
- Each increments once per cycle in which the corresponding condition drives outputs (hazard stall, memory stall, flushD). They wrap modulo 2^32 and clear on reset.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - the FSM state encoding (RUN=2'd0, HAZ=2'd1, MEM=2'd2, REL=2'd3);
  - the default MAX_HAZ_STALL;
  - the stats counter width constant.
- One natural sub-module, sat_counter: a parameterised saturating up-counter with synchronous clear. It is used for stallCycles and, with saturation disabled, for the stats counters.

Test Plan:
- Reset mid-stall: hold hazardDetected=1 for 2 cycles, then pulse reset → outputs 0 immediately; stallCycles=0; timeoutErr=0; state RUN.
- Single hazard: hazardDetected=1 for 2 cycles → stallF=stallD=flushE=1 in both cycles; stallCycles 1 then 2; all outputs 0 and counter 0 on the third cycle.
- Watchdog: hazardDetected held high 6 cycles with MAX_HAZ_STALL=3 → stall in cycles 1-3; cycle 4 all outputs 0 (REL) and timeoutErr=1; stall resumes in cycle 5; timeoutErr remains 1.
- Memory priority: memBusyM=1 and hazardDetected=1 together for 5 cycles → stallF/D/E/M=1, flushE=0 every cycle; no REL; timeoutErr stays 0; stallCycles reaches 5.
- Branch vs hazard: branchTakenD=1 with hazardDetected=1 → flushD=0, flushE=1. Next cycle branchTakenD=1 alone → flushD=1 only.
- With STALL_STATS_EN: run scenarios 2 and 5 back to back → hazStallTotal=3, flushTotal=1, memStallTotal=0.
